// File: rtl/rr_reg_arbiter_if.sv
// rr_reg_arbiter_if -- requester/register bus for rr_reg_arbiter.
// The master side (requesters) drives the request, lock and write data.
// The slave side (the arbiter) returns the grant and the shared register.
interface rr_reg_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int N     = 4
);
    logic [N-1:0]         req;
    logic [N-1:0]         lock;
    logic [N*WIDTH-1:0]   wdata;
    logic [N-1:0]         gnt;
    logic [WIDTH-1:0]     q;
    logic                 q_valid;
    logic [$clog2(N)-1:0] owner;

    modport master (
        output req,
        output lock,
        output wdata,
        input  gnt,
        input  q,
        input  q_valid,
        input  owner
    );

    modport slave (
        input  req,
        input  lock,
        input  wdata,
        output gnt,
        output q,
        output q_valid,
        output owner
    );
endinterface

// File: rtl/rr_reg_arbiter.sv
// rr_reg_arbiter -- round-robin arbiter in front of one shared register.
// The winner of each edge writes its data into q in the same edge that
// raises its grant. Optional grant locking is built only when the macro
// RR_ARB_LOCK_EN is defined; without it the lock inputs are ignored and
// the design is a pure round-robin arbiter.
module rr_reg_arbiter #(
    parameter int WIDTH    = 8,
    parameter int N        = 4,
    parameter int LOCK_MAX = 8
) (
    input  logic               clk,
    input  logic               reset,
    rr_reg_arbiter_if.slave    bus
);
    localparam int IW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic [IW-1:0]    ptr_q, ptr_d;

    logic [N-1:0]     arb_mask_s;
    logic             do_arb_s;
    logic [IW:0]      pick_s;
    logic [IW-1:0]    win_s;

`ifdef RR_ARB_LOCK_EN
    localparam int CW = $clog2(LOCK_MAX + 1);

    logic [CW-1:0]    lock_cnt_q, lock_cnt_d;
    logic             lock_hold_s;
    logic             lock_limit_s;
    logic [N-1:0]     owner_oh_s;
`endif

    // Search mask starting at 'start', ascending modulo N; returns {found, index}.
    // Scanning from the far end down lets the nearest requester overwrite the result.
    function automatic logic [IW:0] rr_pick(input logic [N-1:0] mask,
                                            input logic [IW-1:0] start);
        logic [IW:0] res;
        int          idx;
        res = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(start) + k) % N;
            res = mask[idx] ? {1'b1, IW'(idx)} : res;
        end
        return res;
    endfunction

    // One-hot encoding of a requester index.
    function automatic logic [N-1:0] onehot(input logic [IW-1:0] idx);
        logic [N-1:0] res;
        res      = '0;
        res[idx] = 1'b1;
        return res;
    endfunction

    // Pointer position just after the winner, wrapping N-1 back to 0.
    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] w);
        return (w == IW'(N - 1)) ? '0 : w + IW'(1);
    endfunction

    // Next-state logic: either hold the locked grant or arbitrate from ptr.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        arb_mask_s = bus.req;
        do_arb_s   = 1'b1;
`ifdef RR_ARB_LOCK_EN
        lock_cnt_d   = '0;
        owner_oh_s   = onehot(owner_q);
        lock_hold_s  = bus.lock[owner_q] & bus.req[owner_q];
        // The current LOCKED cycle is the LOCK_MAX-th one held.
        lock_limit_s = (lock_cnt_q == CW'(LOCK_MAX - 1));
        case (state_q)
            GRANT: begin
                if (lock_hold_s) begin
                    do_arb_s = 1'b0;
                end else begin
                    do_arb_s = 1'b1;
                end
            end
            LOCKED: begin
                if (lock_hold_s && !lock_limit_s) begin
                    do_arb_s   = 1'b0;
                    lock_cnt_d = lock_cnt_q + CW'(1);
                end else if (lock_limit_s && (|(bus.req & ~owner_oh_s))) begin
                    // Forced release: give everybody else a turn first.
                    arb_mask_s = bus.req & ~owner_oh_s;
                end else begin
                    arb_mask_s = bus.req;
                end
            end
            default: begin
                do_arb_s = 1'b1;
            end
        endcase
`endif
        pick_s = rr_pick(arb_mask_s, ptr_q);
        win_s  = pick_s[IW-1:0];

        if (!do_arb_s) begin
            // Locked owner keeps grant, owner and pointer; it rewrites q every cycle.
            state_d = LOCKED;
            data_d  = bus.wdata[owner_q*WIDTH +: WIDTH];
            valid_d = 1'b1;
        end else if (pick_s[IW]) begin
            state_d = GRANT;
            gnt_d   = onehot(win_s);
            data_d  = bus.wdata[win_s*WIDTH +: WIDTH];
            valid_d = 1'b1;
            owner_d = win_s;
            ptr_d   = next_ptr(win_s);
        end else begin
            state_d = IDLE;
            gnt_d   = '0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            owner_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef RR_ARB_LOCK_EN
    // Lock hold counter; cleared on entry to LOCKED and outside LOCKED.
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_cnt_q <= '0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
        end
    end
`endif

    assign bus.gnt     = gnt_q;
    assign bus.q       = data_q;
    assign bus.q_valid = valid_q;
    assign bus.owner   = owner_q;

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// tb_rr_reg_arbiter -- directed scoreboard bench for rr_reg_arbiter
// (WIDTH=8, N=4, LOCK_MAX=8). Expectations follow RR_ARB_LOCK_EN.
module tb_rr_reg_arbiter;
    localparam int WIDTH    = 8;
    localparam int N        = 4;
    localparam int LOCK_MAX = 8;

    typedef struct {
        logic [N-1:0]     gnt;
        logic [WIDTH-1:0] q;
        logic             v;
        logic [1:0]       owner;
        string            tag;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    rr_reg_arbiter_if #(.WIDTH(WIDTH), .N(N)) bus ();

    rr_reg_arbiter #(
        .WIDTH    (WIDTH),
        .N        (N),
        .LOCK_MAX (LOCK_MAX)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [N*WIDTH-1:0] pack4(input logic [7:0] d0, input logic [7:0] d1,
                                                 input logic [7:0] d2, input logic [7:0] d3);
        return {d3, d2, d1, d0};
    endfunction

    function automatic exp_t mk(input logic [3:0] g, input logic [7:0] qv, input logic v,
                                input logic [1:0] o, input string tag);
        exp_t e;
        e.gnt = g; e.q = qv; e.v = v; e.owner = o; e.tag = tag;
        return e;
    endfunction

    task automatic check_out();
        exp_t e;
        total++;
        assert (sb.size() != 0) else begin
            bad++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            total++;
            assert (bus.gnt === e.gnt) else begin
                bad++;
                $error("FAIL %s.gnt observed=%b expected=%b", e.tag, bus.gnt, e.gnt);
            end
            total++;
            assert (bus.q === e.q) else begin
                bad++;
                $error("FAIL %s.q observed=%h expected=%h", e.tag, bus.q, e.q);
            end
            total++;
            assert (bus.q_valid === e.v) else begin
                bad++;
                $error("FAIL %s.q_valid observed=%b expected=%b", e.tag, bus.q_valid, e.v);
            end
            total++;
            assert (bus.owner === e.owner) else begin
                bad++;
                $error("FAIL %s.owner observed=%0d expected=%0d", e.tag, bus.owner, e.owner);
            end
        end
    endtask

    task automatic step(input logic rst, input logic [3:0] r, input logic [3:0] l,
                        input logic [N*WIDTH-1:0] wd, input exp_t e);
        reset     = rst;
        bus.req   = r;
        bus.lock  = l;
        bus.wdata = wd;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        logic [N*WIDTH-1:0] wd;
        logic [1:0]         o;
        logic [7:0]         d;

        // Reset dominates requests and locks.
        for (int i = 0; i < 2; i++)
            step(1'b1, 4'b1111, 4'b1111, pack4(8'h11, 8'h22, 8'h33, 8'h44),
                 mk(4'b0000, 8'h00, 1'b0, 2'd0, "reset"));

        // Single write, then q holds while q_valid drops.
        step(1'b0, 4'b0100, 4'b0000, pack4(8'h00, 8'h00, 8'hA5, 8'h00),
             mk(4'b0100, 8'hA5, 1'b1, 2'd2, "single"));
        step(1'b0, 4'b0000, 4'b0000, pack4(8'h00, 8'h00, 8'h5A, 8'h00),
             mk(4'b0000, 8'hA5, 1'b0, 2'd2, "hold"));

        // Reset pulse returns ptr to 0, then full rotation twice.
        step(1'b1, 4'b0000, 4'b0000, pack4(8'h00, 8'h00, 8'h00, 8'h00),
             mk(4'b0000, 8'h00, 1'b0, 2'd0, "reset2"));
        for (int i = 0; i < 8; i++) begin
            o = 2'(i % 4);
            d = 8'(8'h11 * (i % 4 + 1));
            step(1'b0, 4'b1111, 4'b0000, pack4(8'h11, 8'h22, 8'h33, 8'h44),
                 mk(4'(1 << o), d, 1'b1, o, "rotate"));
        end

        // Sparse requests: winner 3 must wrap the pointer to 0.
        wd = pack4(8'h01, 8'h02, 8'h03, 8'h04);
        step(1'b0, 4'b1010, 4'b0000, wd, mk(4'b0010, 8'h02, 1'b1, 2'd1, "sparse1"));
        step(1'b0, 4'b1010, 4'b0000, wd, mk(4'b1000, 8'h04, 1'b1, 2'd3, "sparse3"));
        step(1'b0, 4'b1010, 4'b0000, wd, mk(4'b0010, 8'h02, 1'b1, 2'd1, "wrap"));
        step(1'b0, 4'b0000, 4'b0000, wd, mk(4'b0000, 8'h02, 1'b0, 2'd1, "idle"));

        // Lock stimulus: req 0011, lock[0] held.
        step(1'b1, 4'b0000, 4'b0000, pack4(8'h00, 8'h00, 8'h00, 8'h00),
             mk(4'b0000, 8'h00, 1'b0, 2'd0, "reset3"));
        for (int i = 0; i < LOCK_MAX + 4; i++) begin
`ifdef RR_ARB_LOCK_EN
            if (i <= LOCK_MAX)          o = 2'd0;
            else if (i == LOCK_MAX + 1) o = 2'd1;
            else                        o = 2'd0;
`else
            o = 2'(i % 2);
`endif
            d  = (o == 2'd0) ? 8'(8'h50 + i) : 8'(8'h60 + i);
            wd = pack4(8'(8'h50 + i), 8'(8'h60 + i), 8'hEE, 8'hEE);
            step(1'b0, 4'b0011, 4'b0001, wd, mk(4'(1 << o), d, 1'b1, o, "lock"));
        end

        // Reset in the middle of a held grant, then restart from ptr 0.
        step(1'b1, 4'b0011, 4'b0001, pack4(8'h77, 8'h88, 8'h00, 8'h00),
             mk(4'b0000, 8'h00, 1'b0, 2'd0, "reset_lock"));
        step(1'b0, 4'b0011, 4'b0001, pack4(8'h77, 8'h88, 8'h00, 8'h00),
             mk(4'b0001, 8'h77, 1'b1, 2'd0, "restart"));

        total++;
        assert (sb.size() == 0) else begin
            bad++;
            $error("FAIL scoreboard_left observed=%0d expected=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
